conv_window_gen: RTL and testbench
==================================

# conv_window_gen

Streaming 3x3 window generator that sits directly upstream of the convolution MAC. It accepts a raster-order pixel stream, one pixel per handshake, and holds the two previous image rows in line buffers. For every valid (no-padding) 3x3 position it emits a registered 144-bit window, packed exactly as the MAC consumes it. Downstream, the MAC pipeline carries `win_valid` alongside its 3-cycle datapath.

## Interface
- `WT_BITS`, 16, pixel width in bits (signed, two's complement).
- `IMG_W`, 28, image width in pixels, ≥ 3.
- `IMG_H`, 28, image height in pixels, ≥ 3.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `clr` input 1: synchronous frame restart.
- `in_valid` input 1: `in_pixel` is valid.
- `in_ready` output 1: block can accept a pixel.
- `in_pixel` input `WT_BITS`: raster-order pixel.
- `win_valid` output 1: `win_data` holds a window.
- `out_ready` input 1: downstream accepts the window.
- `win_data` output `9*WT_BITS`: 3x3 window.
- `win_row` output `$clog2(IMG_H)`: output-map row of the window, 0..IMG_H-3.
- `win_col` output `$clog2(IMG_W)`: output-map column of the window, 0..IMG_W-3.
- `frame_done` output 1: one-cycle pulse when the last pixel of a frame is accepted.

## Operation
- Accept: `acc = in_valid & in_ready`.
- Ready: `in_ready = !win_valid | out_ready`. This is combinational, and there is no combinational path from `in_valid`.
- Counters:
  - `col` runs 0..IMG_W-1 and wraps to 0.
  - `row` increments on each `col` wrap and runs 0..IMG_H-1.
  - Both counters wrap to 0 after pixel (IMG_H-1, IMG_W-1); that same cycle `frame_done` is asserted.
- Line buffers:
  - Two IMG_W-deep buffers, `lb0` = row r-1 and `lb1` = row r-2.
  - Both are addressed by `col`.
  - On each accept: read `lb0[col]` and `lb1[col]`, write `in_pixel` into `lb0[col]`, and write the old `lb0[col]` into `lb1[col]`.
- Window registers:
  - A 3x3 shift array; each accept shifts the columns left.
  - The new right column (top to bottom) is `lb1[col]`, `lb0[col]`, `in_pixel`.
- Emit condition: an accept with `row ≥ 2` and `col ≥ 2` emits the window covering rows r-2..r and cols c-2..c.
  - On emit, `win_data` is loaded from the next-state window, `win_row` = r-2, `win_col` = c-2, and `win_valid` is set.
- Packing, MSB first:
  - [143:128] = top-left (r-2, c-2).
  - Then row-major through the window.
  - [15:0] = bottom-right (r, c), which is the newest pixel.
- Hold and clear:
  - `win_valid` clears when `out_ready` is high and there is no emit that cycle.
  - An emit while `out_ready` is high replaces the window back-to-back with no gap.
  - While `win_valid & !out_ready`, `win_data`, `win_row` and `win_col` are held stable.
- Row-boundary windows: the window registers contain stale columns at `col` 0..1. They are never emitted, so no flush is required.
- Frame count: each frame yields exactly (IMG_H-2)*(IMG_W-2) windows; 676 at the defaults.
- `clr` takes priority over an accept in the same cycle:
  - The pixel is dropped.
  - `row`, `col`, `win_valid` and `frame_done` are zeroed.
  - Line-buffer and window contents are left as-is; they are don't-care until overwritten.
- The datapath only moves data; there is no arithmetic and no width change.

## Timing
- Reset values:
  - `win_valid`, `win_data`, `win_row`, `win_col`, `frame_done`, `row`, `col`, and the window registers are all 0.
  - `in_ready` = 1.
- Latency: 1 cycle. The window for pixel (r, c) is visible on the cycle after that pixel's accept.
- Throughput: 1 pixel/cycle, and 1 window/cycle in steady state.
- Line-buffer read and write use the same address in the same cycle, with read-before-write semantics.
- `rst` mid-frame: everything returns to the reset values immediately. The next accepted pixel is treated as (0, 0).
- `frame_done` is registered and asserted for the single cycle after the last accept. It coincides with `win_valid` of the final window.

## Structure
- Package `conv_pkg` holds:
  - `WT_BITS`, `IMG_W`, `IMG_H` defaults.
  - `WIN_BITS = 9*WT_BITS`.
  - A `pixel_t` typedef.
  - The window-slot index constants used to pack `win_data`; these are shared with the MAC.
- Sub-module `line_buffer`: IMG_W x WT_BITS storage with a single address, a write enable, and read-before-write behaviour. It is instantiated twice (or once at 2*WT_BITS width), and is the only mappable memory in the block.

## Test plan
All scenarios use the defaults (IMG_W = IMG_H = 28).
- **First window:** stream pixel = 28*r + c, with `in_valid` and `out_ready` held high.
  - The first `win_valid` appears on the cycle after the 59th accept (pixel 58).
  - `win_data` slots = 0, 1, 2, 28, 29, 30, 56, 57, 58; `win_row` = `win_col` = 0.
- **Full frame:** stream all 784 pixels.
  - Exactly 676 windows, each with bottom-right slot 28*(row+2) + (col+2).
  - `frame_done` pulses once, after pixel 783.
- **Backpressure:** drop `out_ready` low for 5 cycles mid-row.
  - `in_ready` falls to 0 and `win_data` stays stable.
  - On release, no window is lost or duplicated; the 676-window count still holds.
- **Back-to-back frames:** send frame 2 with pixel = 1000 + 28*r + c immediately after frame 1.
  - The first frame-2 window is 1000, 1001, 1002, 1028, … 1058, with no frame-1 values.
- **`clr` mid-frame:** assert `clr` at pixel 300, together with `in_valid`, then restart the frame.
  - The pixel presented with `clr` is dropped and `win_valid` goes to 0 next cycle.
  - The first window again appears after the 59th pixel of the restarted frame.
- **Async reset mid-frame:** assert `rst` at pixel 400.
  - All outputs are 0 immediately and `in_ready` = 1.
  - After release, the behaviour of the First-window scenario repeats.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 window generator and the convolution MAC.
// Slot indices give the position of each pixel inside the packed window.
package conv_pkg;

  localparam int WT_BITS  = 16;
  localparam int IMG_W    = 28;
  localparam int IMG_H    = 28;
  localparam int WIN_ROWS = 3;
  localparam int WIN_COLS = 3;
  localparam int N_SLOTS  = WIN_ROWS * WIN_COLS;
  localparam int WIN_BITS = N_SLOTS * WT_BITS;

  typedef logic [WT_BITS-1:0] pixel_t;

  // Slot 0 occupies the most significant bits of the window.
  localparam int SLOT_TL = 0;
  localparam int SLOT_TC = 1;
  localparam int SLOT_TR = 2;
  localparam int SLOT_ML = 3;
  localparam int SLOT_MC = 4;
  localparam int SLOT_MR = 5;
  localparam int SLOT_BL = 6;
  localparam int SLOT_BC = 7;
  localparam int SLOT_BR = 8;

  function automatic int slot_of(input int r, input int c);
    return r * WIN_COLS + c;
  endfunction

  function automatic int slot_lsb(input int slot, input int bits);
    return (N_SLOTS - 1 - slot) * bits;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage: shared read/write address, and the read
// returns the previous contents when the same entry is written this cycle.
module line_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 28
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_data;
    end
  end

  assign rd_data = mem[addr];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift array,
// emitting one registered packed window per valid (unpadded) position.
module conv_window_gen #(
  parameter int WT_BITS = conv_pkg::WT_BITS,
  parameter int IMG_W   = conv_pkg::IMG_W,
  parameter int IMG_H   = conv_pkg::IMG_H
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WT_BITS-1:0]        in_pixel,
  output logic                      win_valid,
  input  logic                      out_ready,
  output logic [9*WT_BITS-1:0]      win_data,
  output logic [$clog2(IMG_H)-1:0]  win_row,
  output logic [$clog2(IMG_W)-1:0]  win_col,
  output logic                      frame_done
);

  import conv_pkg::*;

  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  logic [ROW_W-1:0] row_reg;
  logic [COL_W-1:0] col_reg;
  logic             win_valid_reg;
  logic             frame_done_reg;
  logic [ROW_W-1:0] win_row_reg;
  logic [COL_W-1:0] win_col_reg;
  logic [9*WT_BITS-1:0] win_data_reg;

  // Element 0 is the top-left slot, so the packed vector is already MSB-first.
  logic [0:N_SLOTS-1][WT_BITS-1:0] win_cur_reg;
  logic [0:N_SLOTS-1][WT_BITS-1:0] win_next;

  logic [WT_BITS-1:0] lb_rd [2];
  logic [WT_BITS-1:0] lb_wr [2];

  logic take;
  logic emit;
  logic col_last;
  logic row_last;

  assign in_ready = !win_valid_reg | out_ready;
  assign take     = in_valid & in_ready & !clr;
  assign col_last = (col_reg == COL_W'(IMG_W - 1));
  assign row_last = (row_reg == ROW_W'(IMG_H - 1));
  assign emit     = take && (row_reg >= ROW_W'(2)) && (col_reg >= COL_W'(2));

  // lb0 holds row r-1, lb1 holds row r-2; the displaced lb0 entry ages into lb1.
  assign lb_wr[0] = in_pixel;
  assign lb_wr[1] = lb_rd[0];

  genvar gi, gj;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lb
      line_buffer #(
        .WIDTH (WT_BITS),
        .DEPTH (IMG_W)
      ) u_lb (
        .clk     (clk),
        .we      (take),
        .addr    (col_reg),
        .wr_data (lb_wr[gi]),
        .rd_data (lb_rd[gi])
      );
    end

    for (gi = 0; gi < WIN_ROWS; gi++) begin : g_win_row
      for (gj = 0; gj < WIN_COLS; gj++) begin : g_win_col
        if (gj < WIN_COLS - 1) begin : g_shift
          assign win_next[slot_of(gi, gj)] = win_cur_reg[slot_of(gi, gj + 1)];
        end else if (gi == 0) begin : g_top
          assign win_next[slot_of(gi, gj)] = lb_rd[1];
        end else if (gi == 1) begin : g_mid
          assign win_next[slot_of(gi, gj)] = lb_rd[0];
        end else begin : g_bot
          assign win_next[slot_of(gi, gj)] = in_pixel;
        end
      end
    end
  endgenerate

  // Columns 0..1 of each row leave stale data in the array; they are never emitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cur_reg <= '0;
    end else if (take) begin
      win_cur_reg <= win_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_reg        <= '0;
      col_reg        <= '0;
      win_valid_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      win_data_reg   <= '0;
      win_row_reg    <= '0;
      win_col_reg    <= '0;
    end else if (clr) begin
      row_reg        <= '0;
      col_reg        <= '0;
      win_valid_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= take & col_last & row_last;
      if (take) begin
        if (col_last) begin
          col_reg <= '0;
          row_reg <= row_last ? '0 : row_reg + ROW_W'(1);
        end else begin
          col_reg <= col_reg + COL_W'(1);
        end
      end
      if (emit) begin
        win_valid_reg <= 1'b1;
        win_data_reg  <= win_next;
        win_row_reg   <= row_reg - ROW_W'(2);
        win_col_reg   <= col_reg - COL_W'(2);
      end else if (out_ready) begin
        win_valid_reg <= 1'b0;
      end
    end
  end

  assign win_valid  = win_valid_reg;
  assign win_data   = win_data_reg;
  assign win_row    = win_row_reg;
  assign win_col    = win_col_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: a pixel-level model pushes expected
// windows into a queue at accept time and they are popped on handshake.
module tb_conv_window_gen;

  localparam int IW = 28;
  localparam int IH = 28;

  typedef struct packed {
    logic [143:0] d;
    logic [4:0]   r;
    logic [4:0]   c;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         clr;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_pixel;
  logic         win_valid;
  logic         out_ready;
  logic [143:0] win_data;
  logic [4:0]   win_row;
  logic [4:0]   win_col;
  logic         frame_done;

  int   n_tests = 0;
  int   n_fail = 0;
  int   dut_win_cnt = 0;
  int   fd_cnt = 0;
  int   mr = 0;
  int   mc = 0;
  logic m_valid = 1'b0;
  logic m_fd = 1'b0;
  logic [15:0] img [IH][IW];
  exp_t q[$];

  conv_window_gen dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .win_valid  (win_valid),
    .out_ready  (out_ready),
    .win_data   (win_data),
    .win_row    (win_row),
    .win_col    (win_col),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [143:0] ramp_win(input int base);
    logic [143:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[(8-k)*16 +: 16] = 16'(base + IW*(k/3) + k%3);
    return w;
  endfunction

  function automatic logic [143:0] model_win(input int r, input int c);
    logic [143:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[(8-k)*16 +: 16] = img[r-2+k/3][c-2+k%3];
    return w;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_fd = 1'b0;
    mr = 0;
    mc = 0;
    q.delete();
  endtask

  // One clock: drive, check handshake side before the edge, update model, check after.
  task automatic cycle(input logic v, input logic [15:0] p, input logic o, input logic c);
    exp_t e;
    logic take;
    logic emit;
    in_valid = v;
    in_pixel = p;
    out_ready = o;
    clr = c;
    #2;
    chk("in_ready", 144'(in_ready), 144'(!m_valid | o));
    if (win_valid && o) dut_win_cnt++;
    if (m_valid && o && q.size() > 0) begin
      e = q.pop_front();
      chk("win_data", win_data, e.d);
      chk("win_row", 144'(win_row), 144'(e.r));
      chk("win_col", 144'(win_col), 144'(e.c));
    end else if (m_valid && q.size() > 0) begin
      chk("hold_data", win_data, q[0].d);
    end
    take = v && (!m_valid || o) && !c;
    emit = take && mr >= 2 && mc >= 2;
    if (c) begin
      model_reset();
    end else begin
      m_fd = take && mr == IH-1 && mc == IW-1;
      if (take) begin
        img[mr][mc] = p;
        if (emit) begin
          e.d = model_win(mr, mc);
          e.r = 5'(mr - 2);
          e.c = 5'(mc - 2);
          q.push_back(e);
        end
        if (mc == IW-1) begin
          mc = 0;
          mr = (mr == IH-1) ? 0 : mr + 1;
        end else begin
          mc++;
        end
      end
      if (emit) m_valid = 1'b1;
      else if (o) m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("win_valid", 144'(win_valid), 144'(m_valid));
    chk("frame_done", 144'(frame_done), 144'(m_fd));
    if (frame_done) fd_cnt++;
  endtask

  // Pixels lo..hi-1 of a frame with value base+index; 5 stall cycles before bp_at.
  task automatic stream(input int base, input int lo, input int hi, input int bp_at);
    for (int i = lo; i < hi; i++) begin
      if (i == bp_at) begin
        for (int k = 0; k < 5; k++) cycle(1'b1, 16'(base + i), 1'b0, 1'b0);
      end
      cycle(1'b1, 16'(base + i), 1'b1, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    in_valid = 1'b0;
    in_pixel = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_win_valid", 144'(win_valid), 144'(0));
    chk("rst_win_data", win_data, 144'(0));
    chk("rst_win_row", 144'(win_row), 144'(0));
    chk("rst_win_col", 144'(win_col), 144'(0));
    chk("rst_frame_done", 144'(frame_done), 144'(0));
    chk("rst_in_ready", 144'(in_ready), 144'(1));
    rst = 1'b0;

    // First window and full frame 1
    stream(0, 0, 58, -1);
    chk("fw_not_yet", 144'(win_valid), 144'(0));
    stream(0, 58, 59, -1);
    chk("fw_valid", 144'(win_valid), 144'(1));
    chk("fw_data", win_data, ramp_win(0));
    chk("fw_pos", 144'({win_row, win_col}), 144'(0));
    stream(0, 59, IW*IH, -1);

    // Frame 2 back-to-back, with backpressure mid-row
    stream(1000, 0, 59, -1);
    chk("f2_first", win_data, ramp_win(1000));
    stream(1000, 59, IW*IH, IW*10 + 15);
    cycle(1'b0, 16'd0, 1'b1, 1'b0);
    chk("two_frame_windows", 144'(dut_win_cnt), 144'(2*676));
    chk("two_frame_done", 144'(fd_cnt), 144'(2));

    // clr mid-frame, then restart
    stream(2000, 0, 300, -1);
    cycle(1'b1, 16'(2300), 1'b1, 1'b1);
    chk("clr_win_valid", 144'(win_valid), 144'(0));
    dut_win_cnt = 0;
    stream(3000, 0, 58, -1);
    chk("clr_fw_not_yet", 144'(win_valid), 144'(0));
    stream(3000, 58, 59, -1);
    chk("clr_fw_data", win_data, ramp_win(3000));
    stream(3000, 59, IW*IH, -1);
    cycle(1'b0, 16'd0, 1'b1, 1'b0);
    chk("clr_frame_windows", 144'(dut_win_cnt), 144'(676));

    // Asynchronous reset mid-frame
    stream(4000, 0, 400, -1);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_win_valid", 144'(win_valid), 144'(0));
    chk("arst_win_data", win_data, 144'(0));
    chk("arst_pos", 144'({win_row, win_col}), 144'(0));
    chk("arst_frame_done", 144'(frame_done), 144'(0));
    chk("arst_in_ready", 144'(in_ready), 144'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    dut_win_cnt = 0;
    stream(5000, 0, 58, -1);
    chk("arst_fw_not_yet", 144'(win_valid), 144'(0));
    stream(5000, 58, 59, -1);
    chk("arst_fw_data", win_data, ramp_win(5000));
    chk("arst_fw_pos", 144'({win_row, win_col}), 144'(0));
    stream(5000, 59, IW*IH, -1);
    cycle(1'b0, 16'd0, 1'b1, 1'b0);
    chk("arst_frame_windows", 144'(dut_win_cnt), 144'(676));
    chk("total_frame_done", 144'(fd_cnt), 144'(4));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
